// File: rtl/wt_dcache_rd_ctrl_mp_pkg.sv
// Shared widths, FSM state encoding and cacheable-region config for the dcache read controller.
// Combinational helpers only; no timing or flow control of its own.
package wt_cache_pkg;

    localparam int DCACHE_SET_ASSOC    = 4;
    localparam int DCACHE_INDEX_WIDTH  = 12;
    localparam int DCACHE_OFFSET_WIDTH = 4;
    localparam int DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
    localparam int DCACHE_TAG_WIDTH    = 52;
    localparam int CACHE_ID_WIDTH      = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MISS_REQ,
        MISS_WAIT,
        KILL_MISS,
        KILL_MISS_ACK,
        REPLAY_REQ,
        REPLAY_READ
    } rd_ctrl_state_e;

    typedef struct packed {
        logic [63:0] cached_base;
        logic [63:0] cached_len;
    } cfg_t;

    localparam cfg_t ArianeDefaultConfig = '{
        cached_base: 64'h0000_0000_8000_0000,
        cached_len:  64'h0000_0000_4000_0000
    };

    function automatic logic is_cacheable(cfg_t cfg, logic [63:0] paddr);
        return (paddr >= cfg.cached_base) && (paddr < (cfg.cached_base + cfg.cached_len));
    endfunction

endpackage

// File: rtl/wt_dcache_rd_ctrl_mp_if.sv
// Bundle of load-port, cache read-port and miss-unit signals around the read controller.
// master = load units / cache / miss unit side, slave = the controller.
interface wt_dcache_rd_ctrl_mp_if #(
    parameter int NumPorts = 2
) ();
    import wt_cache_pkg::*;

    logic                                                cache_en;
    logic [NumPorts-1:0]                                 req;
    logic [NumPorts-1:0][DCACHE_INDEX_WIDTH-1:0]         idx;
    logic [NumPorts-1:0][1:0]                            size;
    logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]           tag;
    logic [NumPorts-1:0]                                 tag_vld;
    logic [NumPorts-1:0]                                 kill;
    logic [NumPorts-1:0]                                 gnt;
    logic [NumPorts-1:0]                                 rvalid;
    logic [63:0]                                         rdata;

    logic                                                miss_req;
    logic                                                miss_ack;
    logic                                                miss_replay;
    logic                                                miss_rtrn_vld;
    logic [63:0]                                         miss_paddr;
    logic                                                miss_nc;
    logic [2:0]                                          miss_size;
    logic [CACHE_ID_WIDTH-1:0]                           miss_id;
    logic [DCACHE_SET_ASSOC-1:0]                         miss_vld_bits;
    logic [DCACHE_SET_ASSOC-1:0]                         miss_ever_hit;

    logic                                                wr_cl_vld;
    logic                                                rd_req;
    logic                                                rd_ack;
    logic [DCACHE_TAG_WIDTH-1:0]                         rd_tag;
    logic [DCACHE_CL_IDX_WIDTH-1:0]                      rd_idx;
    logic [DCACHE_OFFSET_WIDTH-1:0]                      rd_off;
    logic [63:0]                                         rd_data;
    logic [DCACHE_SET_ASSOC-1:0]                         rd_vld_bits;
    logic [DCACHE_SET_ASSOC-1:0]                         rd_ever_hit;
    logic [DCACHE_SET_ASSOC-1:0]                         rd_hit_oh;
    logic                                                replay_sat;

    modport master (
        output cache_en, req, idx, size, tag, tag_vld, kill,
        output miss_ack, miss_replay, miss_rtrn_vld, wr_cl_vld,
        output rd_ack, rd_data, rd_vld_bits, rd_ever_hit, rd_hit_oh,
        input  gnt, rvalid, rdata, miss_req, miss_paddr, miss_nc, miss_size, miss_id,
        input  miss_vld_bits, miss_ever_hit, rd_req, rd_tag, rd_idx, rd_off, replay_sat
    );

    modport slave (
        input  cache_en, req, idx, size, tag, tag_vld, kill,
        input  miss_ack, miss_replay, miss_rtrn_vld, wr_cl_vld,
        input  rd_ack, rd_data, rd_vld_bits, rd_ever_hit, rd_hit_oh,
        output gnt, rvalid, rdata, miss_req, miss_paddr, miss_nc, miss_size, miss_id,
        output miss_vld_bits, miss_ever_hit, rd_req, rd_tag, rd_idx, rd_off, replay_sat
    );

endinterface

// File: rtl/wt_dcache_rd_ctrl_mp_arb.sv
// Round-robin one-hot arbiter: first request at or after the pointer wins, combinationally.
// Pointer moves past the winner only when advance (an acknowledged grant) is high.
module rr_arb_onehot #(
    parameter int NumPorts = 2,
    parameter int IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumPorts-1:0] req,
    input  logic                advance,
    output logic [NumPorts-1:0] gnt,
    output logic [IdxW-1:0]     gnt_idx,
    output logic                gnt_vld
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = IdxW'((int'(ptr_q) + i) % NumPorts);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && gnt_vld) begin
            ptr_q <= (gnt_idx == IdxW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wt_dcache_rd_ctrl_mp.sv
// Multi-port dcache read controller: one RR-arbitrated owner served by a hit/miss/replay FSM.
// Hits complete the cycle the tag is valid; repeated collisions escalate to a non-cacheable miss.
module wt_dcache_rd_ctrl_mp
    import wt_cache_pkg::*;
#(
    parameter int                        NumPorts   = 2,
    parameter logic [CACHE_ID_WIDTH-1:0] RdTxId     = 1,
    parameter int                        MaxReplays = 4,
    parameter cfg_t                      ArianeCfg  = ArianeDefaultConfig
) (
    input  logic                    clk,
    input  logic                    rst,
    wt_dcache_rd_ctrl_mp_if.slave   bus
);

    localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CntW = 4;
    localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxReplays);
    localparam logic [CntW-1:0] MaxCntM1 = CntW'(MaxReplays - 1);

    rd_ctrl_state_e                  state_q, state_d;
    logic [IdxW-1:0]                 owner_q, owner_d;
    logic [CntW-1:0]                 cnt_q;
    logic                            forced_nc_q;
    logic                            rd_ack_q;
    logic                            sat_q;
    logic [DCACHE_TAG_WIDTH-1:0]     tag_q;
    logic [DCACHE_INDEX_WIDTH-1:0]   idx_q;
    logic [1:0]                      size_q;
    logic [DCACHE_SET_ASSOC-1:0]     vld_bits_q, ever_hit_q;

    logic [NumPorts-1:0]             arb_oh;
    logic [IdxW-1:0]                 arb_idx;
    logic                            arb_vld;
    logic                            take_new;
    logic                            enter_replay;
    logic                            latch_tag;
    logic                            latch_way;
    logic                            use_arb_addr;
    logic                            hit;
    logic [NumPorts-1:0]             gnt, rvalid;
    logic                            rd_req, miss_req;
    logic [DCACHE_INDEX_WIDTH-1:0]   rd_addr;
    logic [63:0]                     paddr;
    logic                            nc;

    rr_arb_onehot #(.NumPorts(NumPorts), .IdxW(IdxW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .advance (take_new),
        .gnt     (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign hit = (|bus.rd_hit_oh) & bus.cache_en & ~forced_nc_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        gnt          = '0;
        rvalid       = '0;
        rd_req       = 1'b0;
        miss_req     = 1'b0;
        take_new     = 1'b0;
        enter_replay = 1'b0;
        latch_tag    = 1'b0;
        latch_way    = 1'b0;
        use_arb_addr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    rd_req       = 1'b1;
                    use_arb_addr = 1'b1;
                    take_new     = bus.rd_ack;
                end
            end
            READ, REPLAY_READ: begin
                rd_req = 1'b1;
                if (bus.kill[owner_q]) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = IDLE;
                end else if (bus.tag_vld[owner_q] || state_q == REPLAY_READ) begin
                    latch_tag = (state_q == READ);
                    latch_way = 1'b1;
                    // An escalated load ignores collisions: the array content no longer matters.
                    if (forced_nc_q) begin
                        state_d = MISS_REQ;
                    end else if (bus.wr_cl_vld || !rd_ack_q) begin
                        enter_replay = 1'b1;
                        state_d      = REPLAY_REQ;
                    end else if (hit) begin
                        rvalid[owner_q] = 1'b1;
                        state_d         = IDLE;
                        if (arb_vld) begin
                            use_arb_addr = 1'b1;
                            take_new     = bus.rd_ack;
                        end
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                miss_req = 1'b1;
                if (bus.kill[owner_q]) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = bus.miss_ack ? KILL_MISS : KILL_MISS_ACK;
                end else if (bus.miss_replay) begin
                    enter_replay = 1'b1;
                    state_d      = REPLAY_REQ;
                end else if (bus.miss_ack) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (bus.kill[owner_q]) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = bus.miss_rtrn_vld ? IDLE : KILL_MISS;
                end else if (bus.miss_rtrn_vld) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            KILL_MISS_ACK: begin
                miss_req = 1'b1;
                if (bus.miss_replay) begin
                    state_d = IDLE;
                end else if (bus.miss_ack) begin
                    state_d = KILL_MISS;
                end
            end
            KILL_MISS: begin
                if (bus.miss_rtrn_vld) begin
                    state_d = IDLE;
                end
            end
            REPLAY_REQ: begin
                rd_req = 1'b1;
                if (bus.kill[owner_q]) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = IDLE;
                end else if (bus.rd_ack) begin
                    state_d = REPLAY_READ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_new) begin
            gnt     = arb_oh;
            owner_d = arb_idx;
            state_d = READ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
            forced_nc_q <= 1'b0;
            rd_ack_q    <= 1'b0;
            sat_q       <= 1'b0;
            tag_q       <= '0;
            idx_q       <= '0;
            size_q      <= '0;
            vld_bits_q  <= '0;
            ever_hit_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rd_ack_q <= bus.rd_ack;
            sat_q    <= 1'b0;
            if (take_new) begin
                idx_q       <= bus.idx[arb_idx];
                size_q      <= bus.size[arb_idx];
                cnt_q       <= '0;
                forced_nc_q <= 1'b0;
            end
            if (latch_tag) begin
                tag_q <= bus.tag[owner_q];
            end
            if (latch_way) begin
                vld_bits_q <= bus.rd_vld_bits;
                ever_hit_q <= bus.rd_ever_hit;
            end
            if (enter_replay) begin
                if (cnt_q < MaxCnt) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (cnt_q == MaxCntM1) begin
                    forced_nc_q <= 1'b1;
                    sat_q       <= 1'b1;
                end
            end
        end
    end

    assign rd_addr = use_arb_addr ? bus.idx[arb_idx] : idx_q;
    assign paddr   = {tag_q, idx_q};
    assign nc      = ~bus.cache_en | forced_nc_q | ~is_cacheable(ArianeCfg, paddr);

    assign bus.gnt           = gnt;
    assign bus.rvalid        = rvalid;
    assign bus.rdata         = bus.rd_data;
    assign bus.rd_req        = rd_req;
    assign bus.rd_idx        = rd_addr[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
    assign bus.rd_off        = rd_addr[DCACHE_OFFSET_WIDTH-1:0];
    assign bus.rd_tag        = (state_q == READ) ? bus.tag[owner_q] : tag_q;
    assign bus.miss_req      = miss_req;
    assign bus.miss_paddr    = paddr;
    assign bus.miss_nc       = nc;
    assign bus.miss_size     = nc ? {1'b0, size_q} : 3'b111;
    assign bus.miss_id       = RdTxId;
    assign bus.miss_vld_bits = vld_bits_q;
    assign bus.miss_ever_hit = ever_hit_q;
    assign bus.replay_sat    = sat_q;

endmodule

// File: tb/tb_wt_dcache_rd_ctrl_mp.sv
// Scoreboard bench: stimulus pushes expected grants, completions and miss requests;
// a negedge monitor pops and compares whenever the controller presents them.
module tb_wt_dcache_rd_ctrl_mp;
    import wt_cache_pkg::*;

    localparam int NP = 2;

    typedef struct {
        int          port;
        bit          chk_data;
        logic [63:0] data;
    } rv_t;

    typedef struct {
        logic [63:0] paddr;
        logic        nc;
        logic [2:0]  size;
    } miss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wt_dcache_rd_ctrl_mp_if #(.NumPorts(NP)) bus ();

    wt_dcache_rd_ctrl_mp #(
        .NumPorts   (NP),
        .RdTxId     (2'd1),
        .MaxReplays (4),
        .ArianeCfg  (ArianeDefaultConfig)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rv_t             rv_q[$];
    miss_t           miss_q[$];
    logic [NP-1:0]   gnt_q[$];
    int              vectors     = 0;
    int              miscompares = 0;
    int              sat_cnt     = 0;
    int              sat_base;
    bit              found;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(string name, logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h required nothing", name, act);
    endtask

    // Monitor
    rv_t           mon_rv;
    miss_t         mon_miss;
    logic [NP-1:0] mon_gnt;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.replay_sat) sat_cnt++;
            if (bus.gnt != '0) begin
                if (gnt_q.size() == 0) unexpected("unexpected_gnt", 64'(bus.gnt));
                else begin
                    mon_gnt = gnt_q.pop_front();
                    chk("gnt", 64'(bus.gnt), 64'(mon_gnt));
                end
            end
            if (bus.rvalid != '0) begin
                if (rv_q.size() == 0) unexpected("unexpected_rvalid", 64'(bus.rvalid));
                else begin
                    mon_rv = rv_q.pop_front();
                    chk("rvalid_port", 64'(bus.rvalid), 64'(NP'(1) << mon_rv.port));
                    if (mon_rv.chk_data) chk("rdata", bus.rdata, mon_rv.data);
                end
            end
            if (bus.miss_req && bus.miss_ack) begin
                if (miss_q.size() == 0) unexpected("unexpected_miss", bus.miss_paddr);
                else begin
                    mon_miss = miss_q.pop_front();
                    chk("miss_paddr", bus.miss_paddr, mon_miss.paddr);
                    chk("miss_nc", 64'(bus.miss_nc), 64'(mon_miss.nc));
                    chk("miss_size", 64'(bus.miss_size), 64'(mon_miss.size));
                    chk("miss_id", 64'(bus.miss_id), 64'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cache_en      = 1'b1;
        bus.req           = '0;
        bus.idx           = '0;
        bus.size          = '0;
        bus.tag           = '0;
        bus.tag_vld       = '0;
        bus.kill          = '0;
        bus.miss_ack      = 1'b0;
        bus.miss_replay   = 1'b0;
        bus.miss_rtrn_vld = 1'b0;
        bus.wr_cl_vld     = 1'b0;
        bus.rd_ack        = 1'b1;
        bus.rd_data       = '0;
        bus.rd_vld_bits   = 4'b1111;
        bus.rd_ever_hit   = 4'b0101;
        bus.rd_hit_oh     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(string tagname);
        @(negedge clk);
        chk({tagname, "_gnt"}, 64'(bus.gnt), 64'd0);
        chk({tagname, "_rvalid"}, 64'(bus.rvalid), 64'd0);
        chk({tagname, "_miss_req"}, 64'(bus.miss_req), 64'd0);
        chk({tagname, "_rd_req"}, 64'(bus.rd_req), 64'd0);
        chk({tagname, "_replay_sat"}, 64'(bus.replay_sat), 64'd0);
    endtask

    task automatic do_miss(int p, logic [11:0] idx, logic [51:0] tag, logic [1:0] sz,
                           logic en, logic [3:0] hit_oh, logic [63:0] data,
                           logic exp_nc, logic [2:0] exp_sz);
        idle_inputs();
        bus.cache_en = en;
        bus.req      = NP'(1) << p;
        bus.idx[p]   = idx;
        bus.size[p]  = sz;
        gnt_q.push_back(NP'(1) << p);
        tick();
        bus.req        = '0;
        bus.tag[p]     = tag;
        bus.tag_vld[p] = 1'b1;
        bus.rd_hit_oh  = hit_oh;
        tick();
        bus.tag_vld   = '0;
        bus.rd_hit_oh = '0;
        bus.miss_ack  = 1'b1;
        miss_q.push_back('{paddr: {tag, idx}, nc: exp_nc, size: exp_sz});
        tick();
        bus.miss_ack = 1'b0;
        @(negedge clk);
        chk("miss_wait_no_rvalid", 64'(bus.rvalid), 64'd0);
        chk("miss_wait_no_req", 64'(bus.miss_req), 64'd0);
        tick();
        bus.miss_rtrn_vld = 1'b1;
        bus.rd_data       = data;
        rv_q.push_back('{port: p, chk_data: 1'b1, data: data});
        tick();
        bus.miss_rtrn_vld = 1'b0;
        bus.cache_en      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running required finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk_quiet("reset");

        // Single port-0 hit, tag arriving two cycles after grant
        bus.idx[0] = 12'h120;
        bus.req    = 2'b01;
        gnt_q.push_back(2'b01);
        @(negedge clk);
        chk("hit_rd_req", 64'(bus.rd_req), 64'd1);
        chk("hit_rd_idx", 64'(bus.rd_idx), 64'h12);
        chk("hit_rd_off", 64'(bus.rd_off), 64'h0);
        tick();
        bus.req = '0;
        @(negedge clk);
        chk("hit_no_rvalid_c1", 64'(bus.rvalid), 64'd0);
        tick();
        bus.tag[0]    = 52'h80000;
        bus.tag_vld   = 2'b01;
        bus.rd_hit_oh = 4'b0100;
        bus.rd_data   = 64'hDEAD_BEEF_0000_0001;
        rv_q.push_back('{port: 0, chk_data: 1'b1, data: 64'hDEAD_BEEF_0000_0001});
        @(negedge clk);
        chk("hit_rvalid_c2", 64'(bus.rvalid), 64'b01);
        chk("hit_rd_tag", 64'(bus.rd_tag), 64'h80000);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("hit_back_idle", 64'(bus.rd_req), 64'd0);

        // Back-to-back alternating hits on both ports
        do_reset();
        bus.idx[0]    = 12'h120;
        bus.idx[1]    = 12'h340;
        bus.tag[0]    = 52'h80000;
        bus.tag[1]    = 52'h80001;
        bus.tag_vld   = 2'b11;
        bus.rd_hit_oh = 4'b0001;
        bus.rd_data   = 64'h0123_4567_89AB_CDEF;
        bus.req       = 2'b11;
        gnt_q.push_back(2'b01);
        tick();
        for (int c = 1; c <= 4; c++) begin
            rv_q.push_back('{port: (c % 2 == 1) ? 0 : 1, chk_data: 1'b1, data: 64'h0123_4567_89AB_CDEF});
            if (c < 4) gnt_q.push_back((c % 2 == 1) ? 2'b10 : 2'b01);
            else bus.req = '0;
            tick();
        end
        idle_inputs();

        // Misses: cache disabled, cacheable miss, non-cacheable region
        do_miss(0, 12'h234, 52'h12345, 2'd2, 1'b0, 4'b0001, 64'hAAAA_0000_0000_0003, 1'b1, 3'b010);
        do_miss(1, 12'h340, 52'h80000, 2'd3, 1'b1, 4'b0000, 64'hBBBB_0000_0000_0004, 1'b0, 3'b111);
        do_miss(0, 12'h008, 52'h00001, 2'd1, 1'b1, 4'b0000, 64'hCCCC_0000_0000_0005, 1'b1, 3'b001);

        // Four consecutive write collisions escalate to a forced non-cacheable miss
        idle_inputs();
        sat_base   = sat_cnt;
        bus.req    = 2'b01;
        bus.idx[0] = 12'h120;
        bus.size[0] = 2'b11;
        gnt_q.push_back(2'b01);
        tick();
        bus.req       = '0;
        bus.tag[0]    = 52'h80000;
        bus.tag_vld   = 2'b01;
        bus.rd_hit_oh = 4'b0100;
        bus.wr_cl_vld = 1'b1;
        repeat (7) tick();
        bus.wr_cl_vld = 1'b0;
        bus.miss_ack  = 1'b1;
        miss_q.push_back('{paddr: 64'h0000_0000_8000_0120, nc: 1'b1, size: 3'b011});
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.miss_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("replay_miss_seen", 64'(found), 64'd1);
        tick();
        bus.miss_ack  = 1'b0;
        bus.tag_vld   = '0;
        bus.rd_hit_oh = '0;
        tick();
        bus.miss_rtrn_vld = 1'b1;
        bus.rd_data       = 64'h5A5A_5A5A_0000_0006;
        rv_q.push_back('{port: 0, chk_data: 1'b1, data: 64'h5A5A_5A5A_0000_0006});
        tick();
        bus.miss_rtrn_vld = 1'b0;
        chk("replay_sat_pulses", 64'(sat_cnt - sat_base), 64'd1);

        // Kill in MISS_REQ without ack, then miss-unit replay drops it; non-owner kill ignored
        idle_inputs();
        bus.req    = 2'b10;
        bus.idx[1] = 12'h340;
        gnt_q.push_back(2'b10);
        tick();
        bus.req     = '0;
        bus.tag[1]  = 52'h80001;
        bus.tag_vld = 2'b10;
        bus.kill    = 2'b01;
        tick();
        bus.tag_vld = '0;
        bus.kill    = 2'b10;
        rv_q.push_back('{port: 1, chk_data: 1'b0, data: '0});
        @(negedge clk);
        chk("kill_in_miss_req", 64'(bus.miss_req), 64'd1);
        tick();
        bus.kill        = '0;
        bus.miss_replay = 1'b1;
        @(negedge clk);
        chk("kill_miss_ack_req", 64'(bus.miss_req), 64'd1);
        tick();
        bus.miss_replay = 1'b0;
        @(negedge clk);
        chk("kill_idle_miss_req", 64'(bus.miss_req), 64'd0);
        chk("kill_idle_rd_req", 64'(bus.rd_req), 64'd0);
        repeat (3) tick();

        // Reset while waiting for a miss return
        idle_inputs();
        bus.req    = 2'b01;
        bus.idx[0] = 12'h120;
        gnt_q.push_back(2'b01);
        tick();
        bus.req     = '0;
        bus.tag[0]  = 52'h80000;
        bus.tag_vld = 2'b01;
        tick();
        bus.tag_vld  = '0;
        bus.miss_ack = 1'b1;
        miss_q.push_back('{paddr: 64'h0000_0000_8000_0120, nc: 1'b0, size: 3'b111});
        tick();
        bus.miss_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("mid_miss_reset");
        bus.miss_rtrn_vld = 1'b1;
        tick();
        bus.miss_rtrn_vld = 1'b0;
        @(negedge clk);
        chk("late_rtrn_ignored", 64'(bus.rvalid), 64'd0);
        repeat (3) tick();

        chk("rv_queue_drained", 64'(rv_q.size()), 64'd0);
        chk("miss_queue_drained", 64'(miss_q.size()), 64'd0);
        chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
